// File: rtl/interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer
//
// This block arbitrates the 65C02 reset, NMI, IRQ and BRK sources. It also
// sequences the 7-cycle interrupt entry:
//   boundary -> DUMMY -> S_PCH -> S_PCL -> S_P -> S_VLO -> S_VHI -> IDLE
// Reset takes the same path. It starts from RST_HOLD and needs no
// instruction boundary.
//
// Ports
//   fclk            core clock; all state changes on its rising edge
//   resb            asynchronous active-low reset; also requests the reset
//                   sequence when it is released
//   nmib            NMI pin, active-low, falling-edge sensitive, asynchronous
//   irqb            IRQ pin, active-low, level sensitive, asynchronous
//   rdy             0 freezes the sequencer state and every strobe
//   i_flag          current status I bit (masks IRQ)
//   instr_boundary  pulse in the last cycle of an instruction
//   brk_req         BRK decoded; qualified by instr_boundary
//   busy            sequence in progress (RST_HOLD .. S_VHI)
//   push_pch/pcl/p  stack-cycle strobes
//   stack_write     push cycle writes memory (0 for reset dummy reads)
//   b_flag_out      B bit pushed with P (1 only for BRK)
//   push_resb/nmib/irqb  one-hot vector-low select (FC/FA/FE), S_VLO only
//   load_vec_hi     PCH loads the vector high byte
//   set_i, clear_d  status flag updates
//
// SYNC_STAGES (1..3) sets the depth of the pin synchronizers. The
// pin-to-pending latency for an NMI edge is SYNC_STAGES+1 cycles.
// ---------------------------------------------------------------------------
module interrupt_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic fclk,
  input  logic resb,
  input  logic nmib,
  input  logic irqb,
  input  logic rdy,
  input  logic i_flag,
  input  logic instr_boundary,
  input  logic brk_req,
  output logic busy,
  output logic push_pch,
  output logic push_pcl,
  output logic push_p,
  output logic stack_write,
  output logic b_flag_out,
  output logic push_resb,
  output logic push_nmib,
  output logic push_irqb,
  output logic load_vec_hi,
  output logic set_i,
  output logic clear_d
);

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    DUMMY    = 3'd2,
    S_PCH    = 3'd3,
    S_PCL    = 3'd4,
    S_P      = 3'd5,
    S_VLO    = 3'd6,
    S_VHI    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SRC_RESET = 2'd0,
    SRC_NMI   = 2'd1,
    SRC_IRQ   = 2'd2,
    SRC_BRK   = 2'd3
  } source_t;

  state_t  state_reg, state_next;
  source_t source_reg, source_next;

  logic [SYNC_STAGES-1:0] nmi_sync_reg;
  logic [SYNC_STAGES-1:0] irq_sync_reg;
  logic nmi_synced, irq_synced;
  logic nmi_prev_reg;
  logic nmi_edge;
  logic nmi_pending_reg;
  logic take_nmi;

  // -------------------------------------------------------------------------
  // Pin synchronizers. Both chains preset to 1 (idle pins) so that a reset
  // never creates a false NMI edge.
  // -------------------------------------------------------------------------
  generate
    if (SYNC_STAGES == 1) begin : g_sync_one
      always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
          nmi_sync_reg <= '1;
          irq_sync_reg <= '1;
        end else begin
          nmi_sync_reg <= nmib;
          irq_sync_reg <= irqb;
        end
      end
    end else begin : g_sync_multi
      always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
          nmi_sync_reg <= '1;
          irq_sync_reg <= '1;
        end else begin
          nmi_sync_reg <= {nmi_sync_reg[SYNC_STAGES-2:0], nmib};
          irq_sync_reg <= {irq_sync_reg[SYNC_STAGES-2:0], irqb};
        end
      end
    end
  endgenerate

  assign nmi_synced = nmi_sync_reg[SYNC_STAGES-1];
  assign irq_synced = irq_sync_reg[SYNC_STAGES-1];

  // The falling-edge detector runs regardless of rdy, so a stalled bus
  // cannot swallow an NMI.
  assign nmi_edge = nmi_prev_reg & ~nmi_synced;

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      nmi_prev_reg    <= 1'b1;
      nmi_pending_reg <= 1'b0;
    end else begin
      nmi_prev_reg    <= nmi_synced;
      // A new edge in the same cycle as the acceptance clear wins. This
      // keeps a back-to-back second NMI.
      nmi_pending_reg <= nmi_edge | (nmi_pending_reg & ~take_nmi);
    end
  end

  // -------------------------------------------------------------------------
  // State and source registers
  // -------------------------------------------------------------------------
  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      state_reg  <= RST_HOLD;
      source_reg <= SRC_RESET;
    end else begin
      state_reg  <= state_next;
      source_reg <= source_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next state, source latch and Moore outputs. The outputs depend only on
  // the registered state and source, so rdy=0 freezes them simply by
  // freezing the registers.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    source_next = source_reg;
    take_nmi    = 1'b0;

    busy        = 1'b1;
    push_pch    = 1'b0;
    push_pcl    = 1'b0;
    push_p      = 1'b0;
    stack_write = 1'b0;
    b_flag_out  = 1'b0;
    push_resb   = 1'b0;
    push_nmib   = 1'b0;
    push_irqb   = 1'b0;
    load_vec_hi = 1'b0;
    set_i       = 1'b0;
    clear_d     = 1'b0;

    case (state_reg)
      RST_HOLD: begin
        if (rdy) begin
          state_next  = DUMMY;
          source_next = SRC_RESET;
        end
      end

      IDLE: begin
        busy = 1'b0;
        // The source is fixed here and never re-evaluated mid-sequence.
        if (rdy && instr_boundary) begin
          if (nmi_pending_reg) begin
            state_next  = DUMMY;
            source_next = SRC_NMI;
            take_nmi    = 1'b1;
          end else if (!irq_synced && !i_flag) begin
            state_next  = DUMMY;
            source_next = SRC_IRQ;
          end else if (brk_req) begin
            state_next  = DUMMY;
            source_next = SRC_BRK;
          end
        end
      end

      DUMMY: begin
        if (rdy) state_next = S_PCH;
      end

      S_PCH: begin
        push_pch    = 1'b1;
        stack_write = (source_reg != SRC_RESET);
        if (rdy) state_next = S_PCL;
      end

      S_PCL: begin
        push_pcl    = 1'b1;
        stack_write = (source_reg != SRC_RESET);
        if (rdy) state_next = S_P;
      end

      S_P: begin
        push_p      = 1'b1;
        stack_write = (source_reg != SRC_RESET);
        b_flag_out  = (source_reg == SRC_BRK);
        if (rdy) state_next = S_VLO;
      end

      S_VLO: begin
        // The vector selects exist only here. This keeps them clear of the
        // PCL opcode-load path.
        case (source_reg)
          SRC_RESET: push_resb = 1'b1;
          SRC_NMI:   push_nmib = 1'b1;
          SRC_IRQ:   push_irqb = 1'b1;
          SRC_BRK:   push_irqb = 1'b1;
        endcase
        set_i   = 1'b1;
        clear_d = 1'b1;
        if (rdy) state_next = S_VHI;
      end

      S_VHI: begin
        load_vec_hi = 1'b1;
        if (rdy) state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  localparam int S = 2;

  // Output word layout used by both the model and the comparison.
  localparam int B_BUSY = 11;
  localparam int B_PCH  = 10;
  localparam int B_PCL  = 9;
  localparam int B_P    = 8;
  localparam int B_SW   = 7;
  localparam int B_BF   = 6;
  localparam int B_RESB = 5;
  localparam int B_NMI  = 4;
  localparam int B_IRQ  = 3;
  localparam int B_VHI  = 2;
  localparam int B_SETI = 1;
  localparam int B_CLRD = 0;

  typedef logic [11:0] word_t;
  localparam word_t BUSY_ONLY = 12'h800;

  logic fclk = 1'b0;
  logic resb = 1'b0;
  logic nmib = 1'b1;
  logic irqb = 1'b1;
  logic rdy = 1'b1;
  logic i_flag = 1'b1;
  logic instr_boundary = 1'b0;
  logic brk_req = 1'b0;
  logic busy, push_pch, push_pcl, push_p, stack_write, b_flag_out;
  logic push_resb, push_nmib, push_irqb, load_vec_hi, set_i, clear_d;

  int checks = 0;
  int fails = 0;

  interrupt_sequencer #(.SYNC_STAGES(S)) dut (
    .fclk(fclk), .resb(resb), .nmib(nmib), .irqb(irqb), .rdy(rdy),
    .i_flag(i_flag), .instr_boundary(instr_boundary), .brk_req(brk_req),
    .busy(busy), .push_pch(push_pch), .push_pcl(push_pcl), .push_p(push_p),
    .stack_write(stack_write), .b_flag_out(b_flag_out),
    .push_resb(push_resb), .push_nmib(push_nmib), .push_irqb(push_irqb),
    .load_vec_hi(load_vec_hi), .set_i(set_i), .clear_d(clear_d)
  );

  always #5 fclk = ~fclk;

  function automatic word_t dut_word();
    return {busy, push_pch, push_pcl, push_p, stack_write, b_flag_out,
            push_resb, push_nmib, push_irqb, load_vec_hi, set_i, clear_d};
  endfunction

  // Expected output in cycle k (0=DUMMY .. 5=S_VHI) of a sequence for a
  // given source. Source codes are 0 reset, 1 NMI, 2 IRQ and 3 BRK.
  function automatic word_t seq_word(input int src, input int k);
    word_t w;
    w = BUSY_ONLY;
    case (k)
      1: begin w[B_PCH] = 1'b1; w[B_SW] = (src != 0); end
      2: begin w[B_PCL] = 1'b1; w[B_SW] = (src != 0); end
      3: begin w[B_P] = 1'b1; w[B_SW] = (src != 0); w[B_BF] = (src == 3); end
      4: begin
        if (src == 0) w[B_RESB] = 1'b1;
        else if (src == 1) w[B_NMI] = 1'b1;
        else w[B_IRQ] = 1'b1;
        w[B_SETI] = 1'b1;
        w[B_CLRD] = 1'b1;
      end
      5: w[B_VHI] = 1'b1;
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- behavioural model ----------------
  word_t m_cur;
  word_t m_q[$];
  bit    m_holding;
  bit    m_pending;
  bit    m_edge;
  bit    m_took;
  bit    nh[0:7];   // nh[k] = nmib pin sampled k edges ago
  bit    ih[0:7];

  function automatic void m_load(input int src);
    for (int k = 0; k < 6; k++) m_q.push_back(seq_word(src, k));
    m_cur = m_q.pop_front();
  endfunction

  initial begin
    m_cur = BUSY_ONLY;
    m_holding = 1'b1;
    m_pending = 1'b0;
    for (int k = 0; k < 8; k++) begin nh[k] = 1'b1; ih[k] = 1'b1; end
  end

  always @(posedge fclk or negedge resb) begin
    if (!resb) begin
      m_cur = BUSY_ONLY;
      m_q.delete();
      m_holding = 1'b1;
      m_pending = 1'b0;
      for (int k = 0; k < 8; k++) begin nh[k] = 1'b1; ih[k] = 1'b1; end
    end else begin
      m_took = 1'b0;
      // The pin fell between the samples taken S+1 and S edges ago.
      m_edge = nh[S+1] && !nh[S];
      if (rdy) begin
        if (m_holding) begin
          m_holding = 1'b0;
          m_load(0);
        end else if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
        end else if (m_cur[B_BUSY]) begin
          m_cur = '0;
        end else if (instr_boundary) begin
          if (m_pending) begin m_load(1); m_took = 1'b1; end
          else if (!ih[S] && !i_flag) m_load(2);
          else if (brk_req) m_load(3);
        end
      end
      m_pending = m_edge | (m_pending & !m_took);
      for (int k = 7; k > 1; k--) begin nh[k] = nh[k-1]; ih[k] = ih[k-1]; end
      nh[1] = nmib;
      ih[1] = irqb;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge fclk) begin
    #1;
    checks++;
    if (dut_word() !== m_cur) begin
      fails++;
      $display("FAIL model_compare t=%0t dut=%b expected=%b", $time, dut_word(), m_cur);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // n = cycles after the start negedge until output bit b rises (-1 on timeout).
  task automatic run_seq(input bit pulse, input int b, input int nmi_at, output int n);
    word_t w;
    if (pulse) instr_boundary = 1'b1;
    n = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge fclk);
      instr_boundary = 1'b0;
      brk_req = 1'b0;
      if (c == nmi_at) nmib = 1'b0;
      w = dut_word();
      if (w[b]) begin n = c; break; end
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge fclk);
      n++;
    end while (busy && n < 20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    word_t w;

    // Reset hold and release
    repeat (3) @(negedge fclk);
    check("reset_busy", int'(busy), 1);
    w = dut_word() & ~BUSY_ONLY;
    check("reset_strobes", int'(w), 0);
    resb = 1'b1;
    run_seq(1'b0, B_RESB, 0, n);
    check("reset_vlo_cycle", n, 5);
    wait_idle(n);
    check("reset_idle_after_vhi", n, 2);

    // IRQ masked, then unmasked
    irqb = 1'b0; i_flag = 1'b1;
    repeat (S + 2) @(negedge fclk);
    instr_boundary = 1'b1;
    @(negedge fclk);
    instr_boundary = 1'b0;
    repeat (3) @(negedge fclk);
    check("irq_masked_no_seq", int'(busy), 0);
    i_flag = 1'b0;
    run_seq(1'b1, B_IRQ, 0, n);
    check("irq_vlo_latency", n, 5);
    irqb = 1'b1; i_flag = 1'b1;
    wait_idle(n);

    // NMI beats IRQ; IRQ follows at the next boundary
    irqb = 1'b0; i_flag = 1'b0; nmib = 1'b0;
    repeat (S + 3) @(negedge fclk);
    run_seq(1'b1, B_NMI, 0, n);
    check("nmi_over_irq", n, 5);
    wait_idle(n);
    nmib = 1'b1;
    run_seq(1'b1, B_IRQ, 0, n);
    check("irq_after_nmi", n, 5);
    irqb = 1'b1; i_flag = 1'b1;
    wait_idle(n);

    // BRK
    brk_req = 1'b1;
    run_seq(1'b1, B_BF, 0, n);
    check("brk_bflag_in_sp", n, 4);
    @(negedge fclk);
    check("brk_vector_irq", int'(push_irqb), 1);
    wait_idle(n);

    // NMI edge during S_PCL of a BRK must not hijack it
    repeat (S + 2) @(negedge fclk);
    brk_req = 1'b1;
    run_seq(1'b1, B_IRQ, 3, n);
    check("brk_not_hijacked", n, 5);
    wait_idle(n);
    nmib = 1'b1;
    repeat (2) @(negedge fclk);
    run_seq(1'b1, B_NMI, 0, n);
    check("nmi_taken_next_boundary", n, 5);
    wait_idle(n);

    // rdy stall in S_PCH, then reset in S_P
    irqb = 1'b0; i_flag = 1'b0;
    repeat (S + 2) @(negedge fclk);
    run_seq(1'b1, B_PCH, 0, n);
    check("stall_reach_pch", n, 2);
    irqb = 1'b1;
    rdy = 1'b0;
    repeat (2) begin
      @(negedge fclk);
      check("stall_hold_pch", int'(push_pch), 1);
    end
    rdy = 1'b1;
    repeat (2) @(negedge fclk);
    check("stall_resume_sp", int'(push_p), 1);
    resb = 1'b0;
    #1;
    w = dut_word() & ~BUSY_ONLY;
    check("abort_strobes_zero", int'(w), 0);
    check("abort_busy", int'(busy), 1);
    @(negedge fclk);
    resb = 1'b1; i_flag = 1'b1;
    run_seq(1'b0, B_RESB, 0, n);
    check("restart_reset_seq", n, 5);
    wait_idle(n);

    // Randomised traffic against the model
    repeat (3000) begin
      @(negedge fclk);
      rdy            = ($urandom_range(0, 7) != 0);
      instr_boundary = ($urandom_range(0, 3) == 0);
      brk_req        = $urandom_range(0, 1) == 1;
      i_flag         = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) nmib = ~nmib;
      if ($urandom_range(0, 7) == 0) irqb = ~irqb;
      resb           = ($urandom_range(0, 299) != 0);
    end
    @(negedge fclk);
    resb = 1'b1;
    repeat (2) @(negedge fclk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
